// File: rtl/shared_pkg.sv
// shared_pkg: APB widths and the apb_master FSM state type shared by RTL and bench
package shared_pkg;
  localparam int ADDR_WIDTH = 32;
  localparam int DATA_WIDTH = 32;
  localparam int PSTRB_WIDTH = DATA_WIDTH / 8;
  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} apb_master_state_e;
endpackage

// File: rtl/apb_interface.sv
// APB_interface: bundle of APB requester/completer wires used to hook up apb_master
interface APB_interface;
  import shared_pkg::*;
  logic [ADDR_WIDTH-1:0] PADDR;
  logic [2:0] PPROT;
  logic PSELx;
  logic PENABLE;
  logic PWRITE;
  logic [DATA_WIDTH-1:0] PWDATA;
  logic [PSTRB_WIDTH-1:0] PSTRB;
  logic [DATA_WIDTH-1:0] PRDATA;
  logic PREADY;
  logic PSLVERR;
endinterface

// File: rtl/apb_master.sv
// apb_master: single-outstanding APB requester with registered outputs and an ACCESS-phase timeout
module apb_master #(
  parameter int ADDR_WIDTH = shared_pkg::ADDR_WIDTH,
  parameter int DATA_WIDTH = shared_pkg::DATA_WIDTH,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                    clk,
  input  logic                    PRESET,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic                    cmd_write,
  input  logic [ADDR_WIDTH-1:0]   cmd_addr,
  input  logic [DATA_WIDTH-1:0]   cmd_wdata,
  input  logic [DATA_WIDTH/8-1:0] cmd_strb,
  input  logic [2:0]              cmd_prot,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [DATA_WIDTH-1:0]   rsp_rdata,
  output logic                    rsp_err,
  output logic                    rsp_timeout,
  output logic [ADDR_WIDTH-1:0]   PADDR,
  output logic [2:0]              PPROT,
  output logic                    PSELx,
  output logic                    PENABLE,
  output logic                    PWRITE,
  output logic [DATA_WIDTH-1:0]   PWDATA,
  output logic [DATA_WIDTH/8-1:0] PSTRB,
  input  logic [DATA_WIDTH-1:0]   PRDATA,
  input  logic                    PREADY,
  input  logic                    PSLVERR
);
  import shared_pkg::*;
  localparam int SW = DATA_WIDTH / 8;
  localparam int CW = TIMEOUT_CYCLES > 0 ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  apb_master_state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
  logic cmd_ready_q, cmd_ready_d;
  logic psel_q, psel_d, penable_q, penable_d, pwrite_q, pwrite_d;
  logic [ADDR_WIDTH-1:0] paddr_q, paddr_d;
  logic [2:0] pprot_q, pprot_d;
  logic [DATA_WIDTH-1:0] pwdata_q, pwdata_d;
  logic [SW-1:0] pstrb_q, pstrb_d;
  logic rsp_valid_q, rsp_valid_d, rsp_err_q, rsp_err_d, rsp_to_q, rsp_to_d;
  logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
  logic tmo;
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    cnt_inc = cnt_q + 1'b1;
    psel_d = psel_q;
    penable_d = penable_q;
    pwrite_d = pwrite_q;
    paddr_d = paddr_q;
    pprot_d = pprot_q;
    pwdata_d = pwdata_q;
    pstrb_d = pstrb_q;
    rsp_valid_d = rsp_valid_q;
    rsp_err_d = rsp_err_q;
    rsp_to_d = rsp_to_q;
    rsp_rdata_d = rsp_rdata_q;
    tmo = (TIMEOUT_CYCLES != 0) && (cnt_inc == CW'(TIMEOUT_CYCLES));
    case (state_q)
      IDLE: if (cmd_valid) begin
        state_d = SETUP;
        cnt_d = '0;
        psel_d = 1'b1;
        penable_d = 1'b0;
        pwrite_d = cmd_write;
        paddr_d = cmd_addr;
        pprot_d = cmd_prot;
        pwdata_d = cmd_write ? cmd_wdata : '0;
        pstrb_d = cmd_write ? cmd_strb : '0;
      end
      SETUP: begin
        state_d = ACCESS;
        penable_d = 1'b1;
      end
      ACCESS: if (PREADY) begin
        state_d = RESP;
        psel_d = 1'b0;
        penable_d = 1'b0;
        rsp_valid_d = 1'b1;
        rsp_rdata_d = pwrite_q ? '0 : PRDATA;
        rsp_err_d = PSLVERR;
        rsp_to_d = 1'b0;
      end else begin
        cnt_d = cnt_inc;
        // a late PREADY in the final allowed cycle is handled above, so it beats the abort
        if (tmo) begin
          state_d = RESP;
          psel_d = 1'b0;
          penable_d = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_rdata_d = '0;
          rsp_err_d = 1'b1;
          rsp_to_d = 1'b1;
        end
      end
      RESP: if (rsp_ready) begin
        state_d = IDLE;
        rsp_valid_d = 1'b0;
      end
      default: state_d = IDLE;
    endcase
    cmd_ready_d = state_d == IDLE;
  end
  always_ff @(posedge clk) begin
    if (PRESET) begin
      state_q <= IDLE;
      cnt_q <= '0;
      cmd_ready_q <= 1'b0;
      psel_q <= 1'b0;
      penable_q <= 1'b0;
      pwrite_q <= 1'b0;
      paddr_q <= '0;
      pprot_q <= '0;
      pwdata_q <= '0;
      pstrb_q <= '0;
      rsp_valid_q <= 1'b0;
      rsp_err_q <= 1'b0;
      rsp_to_q <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      cmd_ready_q <= cmd_ready_d;
      psel_q <= psel_d;
      penable_q <= penable_d;
      pwrite_q <= pwrite_d;
      paddr_q <= paddr_d;
      pprot_q <= pprot_d;
      pwdata_q <= pwdata_d;
      pstrb_q <= pstrb_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q <= rsp_err_d;
      rsp_to_q <= rsp_to_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end
  assign cmd_ready = cmd_ready_q;
  assign PSELx = psel_q;
  assign PENABLE = penable_q;
  assign PWRITE = pwrite_q;
  assign PADDR = paddr_q;
  assign PPROT = pprot_q;
  assign PWDATA = pwdata_q;
  assign PSTRB = pstrb_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_err = rsp_err_q;
  assign rsp_timeout = rsp_to_q;
  assign rsp_rdata = rsp_rdata_q;
endmodule

// File: tb/tb_apb_master.sv
// tb_apb_master: table-driven and randomized transfers against a rule-based expectation model
module tb_apb_master;
  import shared_pkg::*;
  localparam int TO = 16;
  localparam int AW = 4 + ADDR_WIDTH + DATA_WIDTH + PSTRB_WIDTH;
  typedef struct {
    logic w;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] wdata;
    logic [PSTRB_WIDTH-1:0] strb;
    logic [2:0] prot;
    int waits;
    logic [DATA_WIDTH-1:0] rdata;
    logic slverr;
    int rsp_delay;
    logic hold;
    logic [DATA_WIDTH-1:0] exp_rdata;
    logic exp_err;
    logic exp_to;
  } vec_t;

  logic clk = 1'b0;
  logic PRESET = 1'b1;
  logic cmd_valid = 1'b0, cmd_ready, cmd_write = 1'b0;
  logic [ADDR_WIDTH-1:0] cmd_addr = '0;
  logic [DATA_WIDTH-1:0] cmd_wdata = '0;
  logic [PSTRB_WIDTH-1:0] cmd_strb = '0;
  logic [2:0] cmd_prot = '0;
  logic rsp_valid, rsp_ready = 1'b0, rsp_err, rsp_timeout;
  logic [DATA_WIDTH-1:0] rsp_rdata;
  int n_chk = 0, n_pass = 0;
  vec_t tbl[9];

  APB_interface apb();

  apb_master #(.ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .PRESET(PRESET),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write), .cmd_addr(cmd_addr),
    .cmd_wdata(cmd_wdata), .cmd_strb(cmd_strb), .cmd_prot(cmd_prot),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .rsp_timeout(rsp_timeout),
    .PADDR(apb.PADDR), .PPROT(apb.PPROT), .PSELx(apb.PSELx), .PENABLE(apb.PENABLE),
    .PWRITE(apb.PWRITE), .PWDATA(apb.PWDATA), .PSTRB(apb.PSTRB),
    .PRDATA(apb.PRDATA), .PREADY(apb.PREADY), .PSLVERR(apb.PSLVERR)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
    else n_pass++;
  endtask

  function automatic logic [AW-1:0] apb_now();
    return {apb.PWRITE, apb.PPROT, apb.PADDR, apb.PWDATA, apb.PSTRB};
  endfunction

  // Expected response from the protocol rules: timeout wins only when PREADY never arrives in TO cycles
  function automatic vec_t model(input vec_t v);
    vec_t r = v;
    r.exp_to = (TO != 0) && (v.waits >= TO);
    r.exp_err = r.exp_to | v.slverr;
    r.exp_rdata = (r.exp_to || v.w) ? '0 : v.rdata;
    return r;
  endfunction

  task automatic xfer(input vec_t v);
    logic [AW-1:0] apb_exp;
    logic [DATA_WIDTH-1:0] ewd;
    logic [PSTRB_WIDTH-1:0] est;
    int n_acc;
    n_acc = (v.waits >= TO) ? TO : v.waits + 1;
    ewd = v.w ? v.wdata : '0;
    est = v.w ? v.strb : '0;
    apb_exp = {v.w, v.prot, v.addr, ewd, est};
    cmd_valid = 1'b1;
    cmd_write = v.w;
    cmd_addr = v.addr;
    cmd_wdata = v.wdata;
    cmd_strb = v.strb;
    cmd_prot = v.prot;
    chk("cmd_ready_idle", {rsp_valid, cmd_ready, apb.PSELx}, 3'b010);
    step();
    cmd_valid = v.hold;
    cmd_write = ~v.w;
    cmd_addr = ~v.addr;
    cmd_wdata = ~v.wdata;
    cmd_strb = ~v.strb;
    cmd_prot = ~v.prot;
    apb.PREADY = 1'b1;
    apb.PSLVERR = 1'b1;
    apb.PRDATA = $urandom;
    chk("setup", {apb.PSELx, apb.PENABLE, rsp_valid, cmd_ready, apb_now()}, {4'b1000, apb_exp});
    step();
    for (int k = 1; k <= n_acc; k++) begin
      apb.PREADY = (k == v.waits + 1);
      apb.PRDATA = apb.PREADY ? v.rdata : ~v.rdata;
      apb.PSLVERR = apb.PREADY ? v.slverr : ~v.slverr;
      chk("access", {apb.PSELx, apb.PENABLE, rsp_valid, cmd_ready, apb_now()}, {4'b1100, apb_exp});
      step();
    end
    apb.PREADY = 1'b0;
    apb.PSLVERR = 1'b1;
    apb.PRDATA = $urandom;
    for (int d = 0; d <= v.rsp_delay; d++) begin
      rsp_ready = (d == v.rsp_delay);
      chk("resp", {apb.PSELx, apb.PENABLE, rsp_valid, cmd_ready, rsp_err, rsp_timeout, rsp_rdata, apb_now()},
          {4'b0010, v.exp_err, v.exp_to, v.exp_rdata, apb_exp});
      step();
    end
    rsp_ready = 1'b0;
    cmd_valid = 1'b0;
    chk("after_resp", {rsp_valid, cmd_ready, apb.PSELx, apb.PENABLE, apb_now()}, {4'b0100, apb_exp});
  endtask

  initial begin
    tbl[0] = '{1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 3'd0, 0, 32'h0BADF00D, 1'b0, 0, 1'b0, 32'h0, 1'b0, 1'b0};
    tbl[1] = '{1'b0, 32'h20, 32'hAAAA5555, 4'hF, 3'd2, 3, 32'h12345678, 1'b0, 1, 1'b0, 32'h12345678, 1'b0, 1'b0};
    tbl[2] = '{1'b1, 32'h30, 32'h01020304, 4'h3, 3'd1, 2, 32'h0, 1'b1, 0, 1'b0, 32'h0, 1'b1, 1'b0};
    tbl[3] = '{1'b0, 32'h40, 32'h0, 4'h0, 3'd0, 16, 32'h55555555, 1'b0, 0, 1'b0, 32'h0, 1'b1, 1'b1};
    tbl[4] = '{1'b0, 32'h44, 32'h0, 4'hF, 3'd0, 15, 32'hCAFEF00D, 1'b0, 0, 1'b0, 32'hCAFEF00D, 1'b0, 1'b0};
    tbl[5] = '{1'b1, 32'h50, 32'h11223344, 4'hC, 3'd3, 1, 32'h0, 1'b0, 5, 1'b1, 32'h0, 1'b0, 1'b0};
    tbl[6] = '{1'b1, 32'h60, 32'h99999999, 4'hF, 3'd5, 20, 32'h0, 1'b0, 2, 1'b0, 32'h0, 1'b1, 1'b1};
    tbl[7] = '{1'b0, 32'hFFFFFFFC, 32'h77777777, 4'hF, 3'd7, 1, 32'hFFFFFFFF, 1'b1, 0, 1'b0, 32'hFFFFFFFF, 1'b1, 1'b0};
    tbl[8] = '{1'b1, 32'h70, 32'hA5A5A5A5, 4'h5, 3'd0, 0, 32'h0, 1'b0, 0, 1'b1, 32'h0, 1'b0, 1'b0};
    apb.PREADY = 1'b0;
    apb.PSLVERR = 1'b0;
    apb.PRDATA = '0;
    step();
    step();
    chk("reset_state", {cmd_ready, rsp_valid, rsp_err, rsp_timeout, rsp_rdata, apb.PSELx, apb.PENABLE, apb_now()}, '0);
    PRESET = 1'b0;
    step();
    chk("cmd_ready_after_reset", {cmd_ready, apb.PSELx, rsp_valid}, 3'b100);
    for (int i = 0; i < 9; i++) xfer(tbl[i]);
    cmd_valid = 1'b1;
    cmd_write = 1'b0;
    cmd_addr = 32'h80;
    cmd_prot = 3'd1;
    step();
    cmd_valid = 1'b0;
    step();
    chk("mid_access", {apb.PSELx, apb.PENABLE}, 2'b11);
    apb.PREADY = 1'b1;
    PRESET = 1'b1;
    step();
    apb.PREADY = 1'b0;
    chk("mid_reset", {apb.PSELx, apb.PENABLE, rsp_valid, cmd_ready, apb_now()}, '0);
    PRESET = 1'b0;
    step();
    chk("post_reset", {apb.PSELx, rsp_valid, cmd_ready}, 3'b001);
    step();
    chk("post_reset_idle", {rsp_valid, cmd_ready}, 2'b01);
    xfer(tbl[1]);
    for (int i = 0; i < 40; i++) begin
      vec_t v;
      v.w = 1'($urandom_range(0, 1));
      v.addr = ADDR_WIDTH'($urandom);
      v.wdata = DATA_WIDTH'($urandom);
      v.strb = PSTRB_WIDTH'($urandom);
      v.prot = 3'($urandom);
      v.waits = $urandom_range(0, 20);
      v.rdata = DATA_WIDTH'($urandom);
      v.slverr = 1'($urandom_range(0, 1));
      v.rsp_delay = $urandom_range(0, 3);
      v.hold = 1'($urandom_range(0, 1));
      xfer(model(v));
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/apb_master.md
APB_MASTER -- requirements
Module: apb_master

Interface
REQ-001 SHALL take parameter ADDR_WIDTH, default shared_pkg::ADDR_WIDTH, APB address width.
REQ-002 SHALL take parameter DATA_WIDTH, default shared_pkg::DATA_WIDTH, APB data width; PSTRB_WIDTH = DATA_WIDTH/8.
REQ-003 SHALL take parameter TIMEOUT_CYCLES, default 16, maximum ACCESS cycles before abort; 0 disables the timeout.
REQ-004 SHALL have the port clk, input, 1 bit: the single clock; all logic samples on its rising edge.
REQ-005 SHALL have the port PRESET, input, 1 bit: reset, synchronous and active-high.
REQ-006 SHALL have the ports cmd_valid (input, 1) and cmd_ready (output, 1): command handshake.
REQ-007 SHALL have the ports cmd_write (in, 1), cmd_addr (in, ADDR_WIDTH), cmd_wdata (in, DATA_WIDTH), cmd_strb (in, PSTRB_WIDTH) and cmd_prot (in, 3): command payload.
REQ-008 SHALL have the ports rsp_valid (out, 1) and rsp_ready (in, 1): response handshake.
REQ-009 SHALL have the ports rsp_rdata (out, DATA_WIDTH), rsp_err (out, 1) and rsp_timeout (out, 1): response payload.
REQ-010 SHALL have the APB requester outputs PADDR (ADDR_WIDTH), PPROT (3), PSELx (1), PENABLE (1), PWRITE (1), PWDATA (DATA_WIDTH) and PSTRB (PSTRB_WIDTH).
REQ-011 SHALL have the APB completer inputs PRDATA (DATA_WIDTH), PREADY (1) and PSLVERR (1).

Function
REQ-012 SHALL implement the FSM states IDLE, SETUP, ACCESS and RESP; every APB and rsp_* output SHALL be registered.
REQ-013 IDLE: cmd_ready=1; cmd_valid&cmd_ready SHALL capture the payload into holding registers and go to SETUP. cmd_ready=0 in all other states.
REQ-014 SETUP: exactly one cycle; PSELx=1, PENABLE=0; PADDR/PWRITE/PPROT/PWDATA/PSTRB driven from the holding registers; next state ACCESS.
REQ-015 ACCESS: PSELx=1, PENABLE=1; every APB output SHALL hold the SETUP value until the transfer ends.
REQ-016 ACCESS with PREADY=1: capture PRDATA into rsp_rdata on reads (0 on writes); capture PSLVERR into rsp_err; rsp_timeout=0; drop PSELx/PENABLE; go to RESP.
REQ-017 PRDATA and PSLVERR SHALL be sampled only when PSELx&PENABLE&PREADY are all 1.
REQ-018 Timeout: a counter SHALL clear on SETUP entry and increment each ACCESS cycle with PREADY=0.
REQ-019 When the counter reaches TIMEOUT_CYCLES, the block SHALL abort: drop PSELx/PENABLE, set rsp_err=1, rsp_timeout=1, rsp_rdata=0, and go to RESP.
REQ-020 If PREADY=1 in the same cycle the timeout would fire, normal completion SHALL win.
REQ-021 RESP: rsp_valid=1, payload stable; rsp_valid&rsp_ready SHALL return the FSM to IDLE, with rsp_valid=0 on the following cycle.
REQ-022 Reads: PSTRB SHALL be driven 0 and PWDATA SHALL be driven 0, regardless of cmd_strb/cmd_wdata.
REQ-023 Outside SETUP/ACCESS: PSELx=0 and PENABLE=0; PADDR/PWDATA/PSTRB/PWRITE/PPROT retain their last values.
REQ-024 Latency: command accepted at cycle N, SETUP at N+1, ACCESS at N+2; with PREADY=1 at N+2, rsp_valid=1 at N+3. Minimum command-to-command spacing is 4 cycles.
REQ-025 No new command SHALL be accepted until the current response is consumed; there is one outstanding transfer at most.

Reset
REQ-026 PRESET=1 at a rising edge SHALL force IDLE and clear the timeout counter.
REQ-027 PRESET=1 SHALL set PSELx=0, PENABLE=0, PWRITE=0, PADDR=0, PWDATA=0, PSTRB=0, PPROT=0, rsp_valid=0, rsp_rdata=0, rsp_err=0 and rsp_timeout=0. cmd_ready SHALL be 0 during reset and 1 on the first cycle after it.
REQ-028 Reset mid-transfer (SETUP/ACCESS/RESP) SHALL discard the transfer with no response; PSELx SHALL be 0 on the next edge.

Structure
REQ-029 ADDR_WIDTH, DATA_WIDTH and PSTRB_WIDTH SHALL come from shared_pkg; the FSM state enum (apb_master_state_e) SHALL be added to shared_pkg for shared use by RTL and bench.
REQ-030 The design SHALL be a single module with no sub-modules; the bench connects it to APB_interface.

Verification
REQ-031 Write 0x10 data 0xDEADBEEF strb 0xF, PREADY=1 immediately -> SETUP/ACCESS one cycle each, PSTRB=0xF, rsp_valid at N+3, rsp_err=0.
REQ-032 Read 0x20, PREADY low 3 ACCESS cycles then high with PRDATA=0x12345678 -> outputs stable throughout, PSTRB=0, rsp_rdata=0x12345678.
REQ-033 Write, PREADY=1 with PSLVERR=1 -> rsp_err=1, rsp_timeout=0; PSLVERR=1 while PREADY=0 is ignored.
REQ-034 TIMEOUT_CYCLES=16, PREADY never asserted -> abort after 16 ACCESS cycles, rsp_err=1, rsp_timeout=1; PREADY rising on the 16th cycle completes normally.
REQ-035 rsp_ready held low 5 cycles with cmd_valid high -> rsp stable and cmd_ready=0 until the response handshake completes.
REQ-036 PRESET asserted during ACCESS -> PSELx=PENABLE=0 next edge, no rsp_valid, and the next command completes cleanly.
